// File: rtl/key_debounce.sv
// Debounces the note switches and octave/hit buttons of a keyboard front panel:
// two-flop synchronizers, per-input stable/counter pairs, and registered outputs.
module key_debounce #(
   parameter int NOTE_KEY_BITS   = 7,
   parameter int DEBOUNCE_CYCLES = 200000,
   parameter int CNT_BITS        = 18
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [NOTE_KEY_BITS-1:0] raw_note_key,
   input  logic                     raw_oct_up,
   input  logic                     raw_oct_down,
   input  logic                     raw_hit,
   output logic [NOTE_KEY_BITS-1:0] note_key,
   output logic                     oct_up,
   output logic                     oct_down,
   output logic                     en_hit,
   output logic                     key_valid
);

   localparam int CH = NOTE_KEY_BITS + 3;
   localparam int UP_IDX = NOTE_KEY_BITS;
   localparam int DN_IDX = NOTE_KEY_BITS + 1;
   localparam int HIT_IDX = NOTE_KEY_BITS + 2;
   localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};
   localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};

   logic [CH-1:0]            raw_s;
   logic [CH-1:0]            sync1_r;
   logic [CH-1:0]            sync2_r;
   logic [CH-1:0]            stable_r;
   logic [CH-1:0]            stable_nxt_s;
   logic [CNT_BITS-1:0]      cnt_r     [CH];
   logic [CNT_BITS-1:0]      cnt_nxt_s [CH];
   logic [1:0]               oct_d_r;
   logic                     up_rise_s;
   logic                     dn_rise_s;
   logic [NOTE_KEY_BITS-1:0] note_nxt_s;
   logic                     valid_nxt_s;
   logic                     up_nxt_s;
   logic                     dn_nxt_s;
   logic                     hit_nxt_s;
   logic [NOTE_KEY_BITS-1:0] note_key_r;
   logic                     key_valid_r;
   logic                     oct_up_r;
   logic                     oct_down_r;
   logic                     en_hit_r;

   // Isolates the lowest set bit; lower note index has priority.
   function automatic logic [NOTE_KEY_BITS-1:0] lowest_set(input logic [NOTE_KEY_BITS-1:0] v);
      return v & (~v + {{(NOTE_KEY_BITS-1){1'b0}}, 1'b1});
   endfunction

   assign raw_s = {raw_hit, raw_oct_down, raw_oct_up, raw_note_key};

   // Two-flop synchronizer for every raw input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= {CH{1'b0}};
         sync2_r <= {CH{1'b0}};
      end else begin
         sync1_r <= raw_s;
         sync2_r <= sync1_r;
      end
   end

   // Per-input debounce: count consecutive differing cycles, accept at the last count.
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         stable_nxt_s[i] = stable_r[i];
         cnt_nxt_s[i]    = CNT_ZERO;
         if (sync2_r[i] != stable_r[i]) begin
            if (cnt_r[i] == CNT_LAST) begin
               stable_nxt_s[i] = sync2_r[i];
            end else begin
               cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end
         end else begin
            cnt_nxt_s[i] = CNT_ZERO;
         end
      end
   end

   // Stable levels, counters and octave edge-detect history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable_r <= {CH{1'b0}};
         oct_d_r  <= 2'b00;
         for (int i = 0; i < CH; i++) begin
            cnt_r[i] <= CNT_ZERO;
         end
      end else begin
         stable_r <= stable_nxt_s;
         oct_d_r  <= {stable_r[DN_IDX], stable_r[UP_IDX]};
         for (int i = 0; i < CH; i++) begin
            cnt_r[i] <= cnt_nxt_s[i];
         end
      end
   end

   assign up_rise_s = stable_r[UP_IDX] & ~oct_d_r[0];
   assign dn_rise_s = stable_r[DN_IDX] & ~oct_d_r[1];

   // Output next-state; simultaneous octave presses cancel each other.
   always_comb begin
      note_nxt_s  = {NOTE_KEY_BITS{1'b0}};
      valid_nxt_s = 1'b0;
      up_nxt_s    = 1'b0;
      dn_nxt_s    = 1'b0;
      hit_nxt_s   = 1'b0;
      if (en) begin
         note_nxt_s  = lowest_set(stable_r[NOTE_KEY_BITS-1:0]);
         valid_nxt_s = |stable_r[NOTE_KEY_BITS-1:0];
         up_nxt_s    = up_rise_s & ~dn_rise_s;
         dn_nxt_s    = dn_rise_s & ~up_rise_s;
         hit_nxt_s   = stable_r[HIT_IDX];
      end else begin
         note_nxt_s  = {NOTE_KEY_BITS{1'b0}};
         valid_nxt_s = 1'b0;
      end
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         note_key_r  <= {NOTE_KEY_BITS{1'b0}};
         key_valid_r <= 1'b0;
         oct_up_r    <= 1'b0;
         oct_down_r  <= 1'b0;
         en_hit_r    <= 1'b0;
      end else begin
         note_key_r  <= note_nxt_s;
         key_valid_r <= valid_nxt_s;
         oct_up_r    <= up_nxt_s;
         oct_down_r  <= dn_nxt_s;
         en_hit_r    <= hit_nxt_s;
      end
   end

   assign note_key  = note_key_r;
   assign key_valid = key_valid_r;
   assign oct_up    = oct_up_r;
   assign oct_down  = oct_down_r;
   assign en_hit    = en_hit_r;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed scenarios plus random stimulus
// against a sample-window reference model.
module tb_key_debounce;

   localparam int N  = 7;
   localparam int D  = 4;
   localparam int CB = 3;
   localparam int W  = N + 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         en = 1'b0;
   logic [N-1:0] raw_note_key = '0;
   logic         raw_oct_up = 1'b0;
   logic         raw_oct_down = 1'b0;
   logic         raw_hit = 1'b0;
   logic [N-1:0] note_key;
   logic         oct_up;
   logic         oct_down;
   logic         en_hit;
   logic         key_valid;

   int total = 0;
   int bad = 0;

   // Reference model: raw sample history (index 0 = newest edge) and accepted levels.
   logic [W-1:0] m_hist [D+2];
   logic [W-1:0] m_stable;
   logic [W-1:0] m_prev;
   logic [N-1:0] e_note;
   logic         e_valid, e_up, e_dn, e_hit;

   key_debounce #(.NOTE_KEY_BITS(N), .DEBOUNCE_CYCLES(D), .CNT_BITS(CB)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .raw_note_key(raw_note_key), .raw_oct_up(raw_oct_up),
      .raw_oct_down(raw_oct_down), .raw_hit(raw_hit),
      .note_key(note_key), .oct_up(oct_up), .oct_down(oct_down),
      .en_hit(en_hit), .key_valid(key_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] first_key(input logic [N-1:0] v);
      logic [N-1:0] r;
      r = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (v[i]) begin
            r = '0;
            r[i] = 1'b1;
         end
      end
      return r;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < D + 2; k++) m_hist[k] = '0;
      m_stable = '0;
      m_prev = '0;
      e_note = '0;
      {e_valid, e_up, e_dn, e_hit} = 4'b0000;
   endtask

   // One clock edge: advance the model, then settle past the edge for sampling.
   task automatic tick();
      logic all_diff, ur, dr;
      @(posedge clk);
      if (!rst_n) begin
         model_clear();
      end else begin
         ur = m_stable[N] && !m_prev[N];
         dr = m_stable[N+1] && !m_prev[N+1];
         e_note  = en ? first_key(m_stable[N-1:0]) : '0;
         e_valid = en && (m_stable[N-1:0] != '0);
         e_up    = en && ur && !dr;
         e_dn    = en && dr && !ur;
         e_hit   = en && m_stable[N+2];
         m_prev  = m_stable;
         for (int k = D + 1; k > 0; k--) m_hist[k] = m_hist[k-1];
         m_hist[0] = {raw_hit, raw_oct_down, raw_oct_up, raw_note_key};
         // A level is accepted once D consecutive synchronized samples all disagree with it.
         for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            for (int k = 2; k <= D + 1; k++) begin
               if (m_hist[k][b] == m_stable[b]) all_diff = 1'b0;
            end
            if (all_diff) m_stable[b] = !m_stable[b];
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_clear();
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if ({note_key, key_valid, oct_up, oct_down, en_hit} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0", {note_key, key_valid, oct_up, oct_down, en_hit});
         end
      end
      rst_n = 1'b1;
      en = 1'b1;
   endtask

   task automatic test_note_latency();
      raw_note_key = 7'b0000100;
      for (int i = 1; i <= 6; i++) begin
         tick();
         total++;
         if ({note_key, key_valid} !== 8'b0) begin
            bad++;
            $display("FAIL note_early: edge %0d got %b/%b want 0/0", i, note_key, key_valid);
         end
      end
      tick();
      total++;
      if (note_key !== 7'b0000100 || key_valid !== 1'b1) begin
         bad++;
         $display("FAIL note_latency: got %b/%b want 0000100/1", note_key, key_valid);
      end
   endtask

   task automatic test_priority();
      raw_note_key = 7'b0110000;
      for (int i = 0; i < 6; i++) tick();
      total++;
      if (note_key !== 7'b0000100) begin
         bad++;
         $display("FAIL prio_hold: got %b want 0000100", note_key);
      end
      tick();
      total++;
      if (note_key !== 7'b0010000 || key_valid !== 1'b1) begin
         bad++;
         $display("FAIL prio_lowest: got %b/%b want 0010000/1", note_key, key_valid);
      end
      raw_note_key = '0;
      for (int i = 0; i < 6; i++) tick();
      total++;
      if (note_key !== 7'b0010000) begin
         bad++;
         $display("FAIL release_hold: got %b want 0010000", note_key);
      end
      tick();
      total++;
      if (note_key !== 7'b0 || key_valid !== 1'b0) begin
         bad++;
         $display("FAIL release_zero: got %b/%b want 0/0", note_key, key_valid);
      end
   endtask

   task automatic test_glitch();
      int highs, first;
      highs = 0;
      first = -1;
      raw_oct_up = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (oct_up) highs++;
      end
      raw_oct_up = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (oct_up) highs++;
      end
      total++;
      if (highs != 0) begin
         bad++;
         $display("FAIL glitch_pulse: got %0d pulses want 0", highs);
      end
      highs = 0;
      raw_oct_up = 1'b1;
      for (int i = 1; i <= 22; i++) begin
         if (i == 11) raw_oct_up = 1'b0;
         tick();
         if (oct_up) begin
            highs++;
            if (first < 0) first = i;
         end
      end
      total++;
      if (highs != 1 || first != 7) begin
         bad++;
         $display("FAIL press_pulse: got count=%0d at=%0d want count=1 at=7", highs, first);
      end
   endtask

   task automatic test_simultaneous();
      int ups, dns;
      ups = 0;
      dns = 0;
      raw_oct_up = 1'b1;
      raw_oct_down = 1'b1;
      for (int i = 0; i < 24; i++) begin
         if (i == 12) begin
            raw_oct_up = 1'b0;
            raw_oct_down = 1'b0;
         end
         tick();
         if (oct_up) ups++;
         if (oct_down) dns++;
      end
      total++;
      if (ups != 0 || dns != 0) begin
         bad++;
         $display("FAIL simul_suppress: got up=%0d dn=%0d want 0/0", ups, dns);
      end
   endtask

   task automatic test_enable();
      int live, dns;
      live = 0;
      dns = 0;
      en = 1'b0;
      raw_oct_down = 1'b1;
      raw_hit = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if ({note_key, key_valid, oct_up, oct_down, en_hit} != '0) live++;
      end
      total++;
      if (live != 0) begin
         bad++;
         $display("FAIL en_low_quiet: got %0d active cycles want 0", live);
      end
      en = 1'b1;
      tick();
      total++;
      if (en_hit !== 1'b1 || oct_down !== 1'b0) begin
         bad++;
         $display("FAIL en_rise: got hit=%b dn=%b want 1/0", en_hit, oct_down);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         if (oct_down) dns++;
      end
      total++;
      if (dns != 0) begin
         bad++;
         $display("FAIL en_no_pulse: got %0d pulses want 0", dns);
      end
      raw_oct_down = 1'b0;
      raw_hit = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      total++;
      if (en_hit !== 1'b0) begin
         bad++;
         $display("FAIL hit_release: got %b want 0", en_hit);
      end
   endtask

   task automatic test_reset_mid();
      raw_hit = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      rst_n = 1'b0;
      model_clear();
      #1;
      total++;
      if (en_hit !== 1'b0) begin
         bad++;
         $display("FAIL rst_hit_clear: got %b want 0", en_hit);
      end
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      total++;
      if (en_hit !== 1'b0) begin
         bad++;
         $display("FAIL rst_hit_early: got %b want 0", en_hit);
      end
      tick();
      total++;
      if (en_hit !== 1'b1) begin
         bad++;
         $display("FAIL rst_hit_accept: got %b want 1", en_hit);
      end
      raw_hit = 1'b0;
      for (int i = 0; i < 8; i++) tick();
   endtask

   task automatic test_random();
      int hold [W];
      logic [W-1:0] r;
      logic [N+3:0] got, want;
      int errs;
      errs = 0;
      r = '0;
      for (int b = 0; b < W; b++) hold[b] = 0;
      for (int c = 0; c < 2000; c++) begin
         for (int b = 0; b < W; b++) begin
            if (hold[b] == 0) begin
               r[b] = 1'($urandom_range(0, 1));
               hold[b] = $urandom_range(1, 2 * D + 2);
            end else begin
               hold[b]--;
            end
         end
         {raw_hit, raw_oct_down, raw_oct_up, raw_note_key} = r;
         if ($urandom_range(0, 49) == 0) en = !en;
         if ($urandom_range(0, 399) == 0) begin
            rst_n = 1'b0;
            model_clear();
         end else begin
            rst_n = 1'b1;
         end
         tick();
         got  = {note_key, key_valid, oct_up, oct_down, en_hit};
         want = {e_note, e_valid, e_up, e_dn, e_hit};
         total++;
         if (got !== want) begin
            bad++;
            errs++;
            if (errs <= 10) $display("FAIL random_cycle %0d: got %b want %b", c, got, want);
         end
      end
      rst_n = 1'b1;
   endtask

   initial begin
      model_clear();
      test_reset();
      test_note_latency();
      test_priority();
      test_glitch();
      test_simultaneous();
      test_enable();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter NOTE_KEY_BITS, default 7, width of the note-key vector (one bit per scale note).
REQ-002 Parameter DEBOUNCE_CYCLES, default 200000, number of consecutive stable clk cycles required to accept a level change (minimum 2).
REQ-003 Parameter CNT_BITS, default 18, counter width; it SHALL satisfy 2^CNT_BITS > DEBOUNCE_CYCLES.
REQ-004 clk  input  1  system clock; the block SHALL use this single clock.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 en  input  1  block enable; high = outputs live.
REQ-007 raw_note_key  input  NOTE_KEY_BITS  raw asynchronous note switches, active-high.
REQ-008 raw_oct_up, raw_oct_down, raw_hit  input  1 each  raw asynchronous buttons, active-high.
REQ-009 note_key  output  NOTE_KEY_BITS  debounced note keys, one-hot or zero.
REQ-010 oct_up, oct_down  output  1 each  single-cycle pulse on a debounced press.
REQ-011 en_hit  output  1  debounced level of the hit button.
REQ-012 key_valid  output  1  high when note_key is non-zero.

Function
REQ-013 Each of the NOTE_KEY_BITS+3 raw inputs SHALL pass through a two-flop synchronizer before any other logic.
REQ-014 Each synchronized input SHALL own a stable register and a CNT_BITS counter.
REQ-015 Synchronized value equal to stable -> counter cleared to 0.
REQ-016 Synchronized value differs from stable -> counter increments by 1 per cycle.
REQ-017 When the counter reaches DEBOUNCE_CYCLES-1 while still differing, stable SHALL take the synchronized value on that edge and the counter SHALL clear.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL never change stable; any return to the stable value mid-count restarts the count from 0.
REQ-019 Latency: a clean raw level change SHALL reach stable exactly DEBOUNCE_CYCLES+2 clk edges after the first edge that samples the new raw value.
REQ-020 note_key SHALL be registered: one-hot of the lowest-index set stable note bit, or all-zero if no bit is set; multiple pressed keys -> lowest index wins.
REQ-021 key_valid SHALL be registered, asserted in the same cycle as a non-zero note_key.
REQ-022 oct_up and oct_down SHALL each pulse high for exactly one cycle, registered, one cycle after their stable bit rises 0->1; a release (1->0) SHALL produce no pulse.
REQ-023 If the stable oct_up and oct_down bits both rise on the same edge, both pulses SHALL be suppressed.
REQ-024 A held octave key SHALL produce one pulse only; no auto-repeat.
REQ-025 en_hit SHALL be the registered stable hit bit, one cycle behind stable.
REQ-026 en low: note_key, key_valid, oct_up, oct_down, en_hit SHALL be 0 on the next edge; synchronizers, counters and stable registers SHALL keep running.
REQ-027 en rising while an octave key is already stable-high SHALL NOT produce a pulse; only a stable 0->1 transition occurring while en is high pulses.
REQ-028 Counter arithmetic SHALL never wrap; REQ-017 caps it at DEBOUNCE_CYCLES-1.

Reset
REQ-029 rst_n low SHALL asynchronously clear all synchronizer flops, stable registers, counters and edge-detect registers to 0.
REQ-030 During and after reset, all outputs SHALL be 0 until a debounced press is accepted.
REQ-031 Reset asserted mid-count SHALL discard the count; after release, a held key SHALL require a full DEBOUNCE_CYCLES+2 cycles to be accepted and SHALL then pulse or assert normally.

Verification (DEBOUNCE_CYCLES=4, NOTE_KEY_BITS=7)
REQ-032 Reset, then raw_note_key=7'b0000100 held -> note_key=7'b0000100 and key_valid=1 appear 7 edges later (6 to stable plus 1 output register); all outputs are 0 before that.
REQ-033 raw_oct_up pulses high for 3 cycles, then high for 10 cycles -> no pulse for the 3-cycle glitch; exactly one oct_up pulse of 1 cycle for the 10-cycle press; none on release.
REQ-034 raw_note_key=7'b0110000 -> note_key=7'b0010000; then raw_note_key=0 -> note_key=0 and key_valid=0 after 7 edges.
REQ-035 raw_oct_up and raw_oct_down rise on the same edge and are held -> neither oct_up nor oct_down pulses.
REQ-036 en=0 while raw_oct_down and raw_hit are held -> outputs stay 0; en=1 -> en_hit=1 on the next edge and no oct_down pulse.
REQ-037 rst_n pulsed low at count 2 of a raw_hit press, raw_hit still held -> en_hit=0 immediately; en_hit=1 exactly 7 edges after rst_n rises.
